// File: rtl/qpu_exu_timer.sv
// Execution-unit timer: advances the trigger time when the time/event queue permits.
// Optional stall watchdog is built in when QPU_TIMER_STALL_TMO_EN is defined.
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 16
`endif

module qpu_exu_timer #(
    parameter int STALL_TMO_W = 10,
    parameter int STALL_TMO   = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tmr_start,
    input  logic                       tmr_stop,
    input  logic                       tmr_clr,
    input  logic                       clk_ena_i,
    output logic                       trigger_o,
    output logic [`QPU_TIME_WIDTH-1:0] trigger_clk_o,
    output logic                       tmr_busy,
    output logic                       tmr_stall,
    output logic                       tmr_ovf,
    output logic                       tmr_tmo
);
    localparam int TW = `QPU_TIME_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_OVF   = 3'd3;
    localparam logic [2:0] S_TMO   = 3'd4;

    generate
        if (STALL_TMO >= (2 ** STALL_TMO_W)) begin : g_bad_tmo
            $error("STALL_TMO does not fit in STALL_TMO_W bits");
        end
    endgenerate

    logic [2:0]    r_state, w_nxt_state;
    logic [TW-1:0] r_time,  w_nxt_time;
    logic          r_ovf,   w_nxt_ovf;
    logic          w_active;

`ifdef QPU_TIMER_STALL_TMO_EN
    localparam logic [STALL_TMO_W-1:0] TMO_VAL = STALL_TMO[STALL_TMO_W-1:0];
    logic [STALL_TMO_W-1:0] r_stall_cnt, w_nxt_cnt;
    logic                   r_tmo,       w_nxt_tmo;
`endif

    assign w_active = (r_state == S_RUN) || (r_state == S_STALL);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_time  = r_time;
        w_nxt_ovf   = r_ovf;
`ifdef QPU_TIMER_STALL_TMO_EN
        w_nxt_cnt   = r_stall_cnt;
        w_nxt_tmo   = r_tmo;
`endif
        if (w_active) begin
            // stop outranks advance, overflow and timeout
            if (tmr_stop) begin
                w_nxt_state = S_IDLE;
`ifdef QPU_TIMER_STALL_TMO_EN
                w_nxt_cnt   = '0;
`endif
            end else if (clk_ena_i) begin
`ifdef QPU_TIMER_STALL_TMO_EN
                w_nxt_cnt = '0;
`endif
                if (r_time == '1) begin
                    w_nxt_ovf   = 1'b1;
                    w_nxt_state = S_OVF;
                end else begin
                    w_nxt_time  = r_time + 1'b1;
                    w_nxt_state = S_RUN;
                end
            end else if (r_state == S_RUN) begin
                w_nxt_state = S_STALL;
`ifdef QPU_TIMER_STALL_TMO_EN
            end else if (r_stall_cnt == TMO_VAL) begin
                w_nxt_state = S_TMO;
                w_nxt_tmo   = 1'b1;
                w_nxt_cnt   = '0;
            end else begin
                w_nxt_cnt = r_stall_cnt + 1'b1;
`endif
            end
        end else begin
            // start wins over clr when both pulse together
            if (tmr_start) begin
                w_nxt_state = S_RUN;
                w_nxt_time  = '0;
                w_nxt_ovf   = 1'b0;
`ifdef QPU_TIMER_STALL_TMO_EN
                w_nxt_tmo   = 1'b0;
                w_nxt_cnt   = '0;
`endif
            end else if (tmr_clr) begin
                w_nxt_ovf = 1'b0;
`ifdef QPU_TIMER_STALL_TMO_EN
                w_nxt_tmo = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_time  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_time  <= w_nxt_time;
            r_ovf   <= w_nxt_ovf;
        end
    end

`ifdef QPU_TIMER_STALL_TMO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_tmo       <= 1'b0;
        end else begin
            r_stall_cnt <= w_nxt_cnt;
            r_tmo       <= w_nxt_tmo;
        end
    end
    assign tmr_tmo = r_tmo;
`else
    assign tmr_tmo = 1'b0;
`endif

    assign trigger_o     = w_active;
    assign tmr_busy      = w_active;
    assign tmr_stall     = (r_state == S_STALL);
    assign tmr_ovf       = r_ovf;
    assign trigger_clk_o = r_time;

endmodule
